// File: rtl/lib_switch_alloc_rr_pkg.sv
// Shared LIB package: pointer-width helper and request/packet types for the switch allocator.
package lib_switch_alloc_rr_pkg;

   localparam int unsigned LIB_SWITCH_M = 4;

   // One request row [0:M-1] of a single input for the default M
   typedef logic [0:LIB_SWITCH_M-1] alloc_req_t;

   typedef struct packed {
      logic [31:0] data;
      logic        tail;
   } packet_t;

   function automatic int unsigned LIB_SWITCH_PTR_W(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lib_switch_alloc_rr_if.sv
// Request/grant bundle between input buffers, allocator and crossbar select.
// i_tail exists only when LIB_SWITCH_ALLOC_LOCK_EN is defined.
interface lib_switch_alloc_rr_if #(
   parameter int unsigned N = 4,
   parameter int unsigned M = 4
);
   logic [0:N-1][0:M-1] i_req;
   logic [0:M-1]        i_out_ready;
`ifdef LIB_SWITCH_ALLOC_LOCK_EN
   logic [0:N-1]        i_tail;
`endif
   logic [0:M-1][0:N-1] o_sel;
   logic [0:N-1]        o_gnt;

`ifdef LIB_SWITCH_ALLOC_LOCK_EN
   modport master (output i_req, i_out_ready, i_tail, input o_sel, o_gnt);
   modport slave  (input i_req, i_out_ready, i_tail, output o_sel, o_gnt);
`else
   modport master (output i_req, i_out_ready, input o_sel, o_gnt);
   modport slave  (input i_req, i_out_ready, output o_sel, o_gnt);
`endif

endinterface

// File: rtl/lib_arb_rr_onehot.sv
// N-way round-robin arbiter with registered priority pointer and one-hot grant.
// LIB_SWITCH_ALLOC_LOCK_EN adds wormhole locking until the tail flit transfers.
module lib_arb_rr_onehot
   import lib_switch_alloc_rr_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         ce,
   input  logic         en,
   input  logic [0:N-1] req,
`ifdef LIB_SWITCH_ALLOC_LOCK_EN
   input  logic [0:N-1] tail,
`endif
   output logic [0:N-1] gnt
);

   localparam int unsigned PtrW = LIB_SWITCH_PTR_W(N);

   logic [PtrW-1:0] ptr_q, ptr_d;
   logic [PtrW-1:0] win, win_inc;
   logic [0:N-1]    cand;
   logic            found;
   logic            xfer;
   int unsigned     idx;

`ifdef LIB_SWITCH_ALLOC_LOCK_EN
   logic            lock_vld_q, lock_vld_d;
   logic [PtrW-1:0] lock_id_q, lock_id_d;

   // A held output sees only its owner, even when the owner is idle
   always_comb begin
      cand = req;
      if (lock_vld_q) begin
         cand            = '0;
         cand[lock_id_q] = req[lock_id_q];
      end
   end
`else
   assign cand = req;
`endif

   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = (32'(ptr_q) + i) % N;
         if (!found && cand[PtrW'(idx)]) begin
            found = 1'b1;
            win   = PtrW'(idx);
         end
      end
      gnt = '0;
      if (found && en && ce && reset_n) gnt[win] = 1'b1;
   end

   assign xfer    = |gnt;
   assign win_inc = (win == PtrW'(N - 1)) ? '0 : win + 1'b1;

   always_comb begin
      ptr_d = ptr_q;
`ifdef LIB_SWITCH_ALLOC_LOCK_EN
      lock_vld_d = lock_vld_q;
      lock_id_d  = lock_id_q;
      if (xfer) begin
         if (tail[win]) begin
            lock_vld_d = 1'b0;
            ptr_d      = win_inc;
         end else begin
            lock_vld_d = 1'b1;
            lock_id_d  = win;
         end
      end
`else
      if (xfer) ptr_d = win_inc;
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ptr_q <= '0;
`ifdef LIB_SWITCH_ALLOC_LOCK_EN
         lock_vld_q <= 1'b0;
         lock_id_q  <= '0;
`endif
      end else begin
         ptr_q <= ptr_d;
`ifdef LIB_SWITCH_ALLOC_LOCK_EN
         lock_vld_q <= lock_vld_d;
         lock_id_q  <= lock_id_d;
`endif
      end
   end

endmodule

// File: rtl/lib_switch_alloc_rr.sv
// Switch allocator: one round-robin arbiter per output, one-hot crossbar select and input grants.
// Packet locking is enabled with LIB_SWITCH_ALLOC_LOCK_EN.
module lib_switch_alloc_rr #(
   parameter int unsigned N = 4,
   parameter int unsigned M = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 ce,
   lib_switch_alloc_rr_if.slave bus
);

   logic [0:M-1][0:N-1] col;
   logic [0:M-1][0:N-1] sel;
   logic [0:N-1]        gnt;

   // Transpose per-input request rows into per-output candidate vectors
   always_comb begin
      col = '0;
      for (int unsigned m = 0; m < M; m++) begin
         for (int unsigned j = 0; j < N; j++) begin
            col[m][j] = bus.i_req[j][m];
         end
      end
   end

   for (genvar m = 0; m < M; m++) begin : g_arb
      lib_arb_rr_onehot #(
         .N(N)
      ) u_arb (
         .clk    (clk),
         .reset_n(reset_n),
         .ce     (ce),
         .en     (bus.i_out_ready[m]),
         .req    (col[m]),
`ifdef LIB_SWITCH_ALLOC_LOCK_EN
         .tail   (bus.i_tail),
`endif
         .gnt    (sel[m])
      );
   end

   always_comb begin
      gnt = '0;
      for (int unsigned m = 0; m < M; m++) gnt = gnt | sel[m];
   end

   assign bus.o_sel = sel;
   assign bus.o_gnt = gnt;

endmodule

// File: doc/lib_switch_alloc_rr.md
Name: lib_switch_alloc_rr

Overview:
- Switch allocator for the NxM one-hot crossbar. It generates the crossbar's per-output one-hot select word and a per-input grant.
- Each output port owns a round-robin arbiter with a registered priority pointer. An optional packet lock holds an output on one input until that input's tail flit transfers.
- The block sits between the input buffers (request/dequeue side) and the crossbar select input.

Parameters:
- N, 4, number of input ports (requesters), N >= 2.
- M, 4, number of output ports (arbitrated resources), M >= 1.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- ce  in  1  clock enable. When 0, all state holds and o_sel/o_gnt are 0.
- i_req  in  [0:N-1][0:M-1]  per-input destination request. One-hot or all-zero per input.
- i_out_ready  in  [0:M-1]  output m can accept a flit this cycle.
- i_tail  in  [0:N-1]  head flit of input j is a packet tail. Present only with LIB_SWITCH_ALLOC_LOCK_EN.
- o_sel  out  [0:M-1][0:N-1]  one-hot select per output, wired directly to the crossbar i_sel. Bit [m][j] set means output m takes input j; the packed value is 1<<(N-1-j).
- o_gnt  out  [0:N-1]  input j's head flit transfers this cycle; input j dequeues it.

Behaviour:
- State per output m:
  - ptr[m], width $clog2(N), reset 0.
  - With the lock feature only: lock_vld[m] (reset 0) and lock_id[m] (width $clog2(N), reset 0).
- Grant path is combinational, zero latency. o_sel and o_gnt are valid in the same cycle as i_req.
- While reset_n==0 or ce==0: o_sel=0 and o_gnt=0.
- Candidate set for output m: C[m] = {j : i_req[j][m]==1}. Arbitration happens only when i_out_ready[m]==1; otherwise o_sel[m]=0.
- Round-robin selection: winner w = first j in C[m] scanning ptr[m], ptr[m]+1, ..., wrapping modulo N.
- Winner outputs: o_sel[m][w]=1, all other bits of o_sel[m] are 0. o_gnt[w]=1.
- Each input requests at most one output, so o_gnt has no conflicts. o_gnt[j] = OR over m of o_sel[m][j].
- Transfer: the cycle in which o_sel[m][w]==1, with ce==1 and reset_n==1.
- Pointer update without the lock feature: on every transfer, ptr[m] <= (w+1) mod N at the next posedge. When w==N-1, ptr wraps to 0.
- No transfer on output m: ptr[m] holds.
- A non-one-hot i_req row is illegal. Behaviour is undefined; the bench flags it with an assertion.
- Fairness: with all N inputs continuously requesting the same ready output, each input wins exactly once every N cycles.
- Reset mid-operation: the next cycle after reset_n=0 sampled, all pointers are 0 and all locks clear. In-flight packets are abandoned; the input buffers are reset alongside.

Optional Feature:
- Macro: LIB_SWITCH_ALLOC_LOCK_EN. When defined, it enables the i_tail port and packet (wormhole) locking.
- Locking rules, with the macro:
  - Transfer of a non-tail flit from input w on unlocked output m sets lock_vld[m]=1 and lock_id[m]=w.
  - While lock_vld[m]==1, only lock_id[m] may win output m. All other requesters are masked, even if lock_id[m] is not currently requesting; o_sel[m]=0 in that case.
  - Transfer with i_tail[lock_id]==1 clears lock_vld[m] and sets ptr[m] <= (lock_id+1) mod N.
  - A single-flit packet (head with i_tail=1) never locks.
- Pointer advances only on tail transfers, so arbitration is per-packet fair.
- Without the macro: no i_tail port, no lock state, every flit is arbitrated independently, and the pointer advances per flit.

Decomposition:
- Shared LIB package: add constant LIB_SWITCH_PTR_W function ($clog2 wrapper), plus an alloc_req_t typedef for the [0:M-1] request row. packet_t is untouched.
- One sub-module: lib_arb_rr_onehot. It is a single N-way round-robin arbiter: request vector, pointer, and enable in; one-hot grant out. It contains the pointer register and, under the macro, the lock logic. It is instantiated M times via generate.
- The top level only transposes i_req into per-output request vectors and OR-reduces grants into o_gnt.

Test Plan:
(N=4, M=2 for all scenarios.)
1. Reset, then inputs 0..3 all request output 0 with i_out_ready=2'b11 for 8 cycles → o_sel[0] sequence 1000,0100,0010,0001,1000,...; o_gnt rotates accordingly; o_sel[1]=0.
2. Input 2 requests output 0 while input 1 requests output 1 → same cycle o_sel[0]=0010, o_sel[1]=0100, o_gnt=0110; ptr[0]=3 and ptr[1]=2 after the edge.
3. Inputs 0 and 3 request output 1 with i_out_ready[1]=0 for 3 cycles, then 1 → o_sel[1]=0 and ptr holds for 3 cycles; then input 0 wins (ptr=0), then input 3.
4. Macro on: input 1 sends head,body,tail to output 0 while input 0 requests throughout → o_sel[0]=0100 for 3 transfers, even with a 1-cycle gap where input 1 drops its request (o_sel[0]=0 then); input 0 is granted only after the tail; ptr[0]=2.
5. Reset asserted mid-packet (macro on, output 0 locked to input 3) → o_sel=0 and o_gnt=0 during reset; after release, input 0 requesting output 0 is granted immediately (lock cleared, ptr=0).
6. ce=0 for 2 cycles with requests pending → o_sel=0 and o_gnt=0, pointers unchanged; grants resume identically when ce=1.
